// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between the control logic and the nibble sequencer.
// The requester owns start/op/a/b; the sequencer owns busy/done/result/cout.
interface alu_seq_ctrl_if #(
   parameter int W = 16
);
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;

   modport master (
      output start, op, a, b,
      input  busy, done, result, cout
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Time-multiplexes a wide add/sub/inc/dec onto a 4-bit arithmetic unit, LSB nibble first.
// Optional zero/ovf flag ports are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_ctrl #(
   parameter int NIBBLES = 4,
   parameter int SETTLE  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_ctrl_if.slave bus,
   output logic [3:0] dp_a,
   output logic [3:0] dp_b,
   output logic       dp_s1,
   output logic       dp_s0,
   output logic       dp_cin,
   input  logic [3:0] dp_d,
   input  logic       dp_cout,
   output logic       dbg_state
`ifdef ALU_SEQ_FLAGS_EN
   ,
   output logic       zero,
   output logic       ovf
`endif
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    res_q;
   logic [W-1:0]    res_cap;
   logic [1:0]      op_q;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic            done_q;
   logic            cout_q;
   logic            capture;
   logic            last;

   // Handshake: start is sampled only in IDLE; busy is high from the accepting edge
   // through the final capture; done pulses for one cycle with result/cout valid.
   assign bus.busy   = (state == RUN);
   assign bus.done   = done_q;
   assign bus.result = res_q;
   assign bus.cout   = cout_q;
   assign dbg_state  = state;

   assign capture = (state == RUN) && (cnt == CW'(SETTLE - 1));
   assign last    = (idx == IW'(NIBBLES - 1));

   always_comb begin
      dp_a = 4'h0;
      dp_b = 4'h0;
      if (state == RUN) begin
         dp_a = a_q[int'(idx) * 4 +: 4];
         dp_b = b_q[int'(idx) * 4 +: 4];
      end
   end

   always_comb begin
      res_cap = res_q;
      res_cap[int'(idx) * 4 +: 4] = dp_d;
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic y_msb;
   always_comb begin
      y_msb = 1'b0;
      case (op_q)
         2'b00:   y_msb = b_q[W-1];
         2'b01:   y_msb = ~b_q[W-1];
         2'b10:   y_msb = 1'b0;
         default: y_msb = 1'b1;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         op_q   <= 2'b00;
         idx    <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
         cout_q <= 1'b0;
         dp_s1  <= 1'b0;
         dp_s0  <= 1'b0;
         dp_cin <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
         zero   <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= RUN;
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  op_q   <= bus.op;
                  idx    <= '0;
                  cnt    <= '0;
                  res_q  <= '0;
                  // op encoding equals the select code; Cin is set for sub and inc only
                  {dp_s1, dp_s0} <= bus.op;
                  dp_cin <= bus.op[1] ^ bus.op[0];
               end
            end
            RUN: begin
               if (capture) begin
                  res_q <= res_cap;
                  cnt   <= '0;
                  if (last) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                     cout_q <= dp_cout;
                     idx    <= '0;
                     dp_s1  <= 1'b0;
                     dp_s0  <= 1'b0;
                     dp_cin <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                     zero   <= (res_cap == '0);
                     ovf    <= (a_q[W-1] == y_msb) && (dp_d[3] != a_q[W-1]);
`endif
                  end else begin
                     idx    <= idx + 1'b1;
                     dp_cin <= dp_cout;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl driving a behavioural 4-bit arithmetic unit from dp_*.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] dp_a, dp_b, dp_d;
   logic       dp_s1, dp_s0, dp_cin, dp_cout;
   logic       dbg_state;
`ifdef ALU_SEQ_FLAGS_EN
   logic       zero, ovf;
`endif

   int checks = 0;
   int errors = 0;

   alu_seq_ctrl_if #(.W(16)) bus ();

   alu_seq_ctrl #(.NIBBLES(4), .SETTLE(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dp_a      (dp_a),
      .dp_b      (dp_b),
      .dp_s1     (dp_s1),
      .dp_s0     (dp_s0),
      .dp_cin    (dp_cin),
      .dp_d      (dp_d),
      .dp_cout   (dp_cout),
      .dbg_state (dbg_state)
`ifdef ALU_SEQ_FLAGS_EN
      ,
      .zero      (zero),
      .ovf       (ovf)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // arithmetic unit: operand mux then ripple-carry adder
   logic [3:0] unit_y;
   always_comb begin
      unit_y = dp_b;
      case ({dp_s1, dp_s0})
         2'b00:   unit_y = dp_b;
         2'b01:   unit_y = ~dp_b;
         2'b10:   unit_y = 4'h0;
         default: unit_y = 4'hF;
      endcase
      {dp_cout, dp_d} = 5'(dp_a) + 5'(unit_y) + 5'(dp_cin);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
   endtask

   // Follows one operation from its accepting edge to done. inject pulses start with
   // junk operands mid-run; chain raises start with the next operands before done.
   task automatic monitor(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res, input logic exp_cout,
                          input logic exp_zero, input logic exp_ovf, input bit inject,
                          input bit chain, input logic [1:0] op2, input logic [15:0] a2,
                          input logic [15:0] b2);
      logic [3:0] ecin;
      logic [3:0] yn;
      logic [4:0] s;
      logic       c;
      int         m;
      int         k;
      c = (op == 2'b01) || (op == 2'b10);
      for (int n = 0; n < 4; n++) begin
         case (op)
            2'b00:   yn = b[n*4 +: 4];
            2'b01:   yn = ~b[n*4 +: 4];
            2'b10:   yn = 4'h0;
            default: yn = 4'hF;
         endcase
         ecin[n] = c;
         s = 5'(a[n*4 +: 4]) + 5'(yn) + 5'(c);
         c = s[4];
      end
      @(negedge clk);
      bus.start = 1'b0;
      m = 0;
      while (bus.done !== 1'b1 && m < 20) begin
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         if (m < 8) begin
            k = m / 2;
            check({tag, "_sel"}, 32'({dp_s1, dp_s0}), 32'(op));
            check({tag, "_cin"}, 32'(dp_cin), 32'(ecin[k]));
            check({tag, "_dpa"}, 32'(dp_a), 32'(a[k*4 +: 4]));
            check({tag, "_dpb"}, 32'(dp_b), 32'(b[k*4 +: 4]));
         end
         if (inject && (m == 1 || m == 4)) begin
            bus.start = 1'b1;
            bus.op    = 2'b01;
            bus.a     = 16'hFFFF;
            bus.b     = 16'h0001;
         end
         if (inject && (m == 2 || m == 5)) bus.start = 1'b0;
         if (chain && m == 7) begin
            bus.start = 1'b1;
            bus.op    = op2;
            bus.a     = a2;
            bus.b     = b2;
         end
         @(posedge clk);
         @(negedge clk);
         m++;
      end
      check({tag, "_latency"}, 32'(m), 32'd8);
      check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
      check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
      check({tag, "_idle_dp"}, 32'({dp_a, dp_b, dp_s1, dp_s0, dp_cin}), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
      if (exp_zero === 1'bx || exp_ovf === 1'bx) $display("note: unknown flag expectation");
`endif
      if (!chain) begin
         @(negedge clk);
         check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
         check({tag, "_result_hold"}, 32'(bus.result), 32'(exp_res));
      end
   endtask

   initial begin
      int ndone;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = 16'h0000;
      bus.b     = 16'h0000;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_cout", 32'(bus.cout), 32'd0);
      check("rst_dp", 32'({dp_a, dp_b, dp_s1, dp_s0, dp_cin}), 32'd0);
      rst_n = 1'b1;

      launch(2'b00, 16'h1234, 16'h0FCD);
      monitor("add", 2'b00, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 0, 0, 2'b00, 16'h0, 16'h0);

      launch(2'b01, 16'h0005, 16'h0007);
      monitor("sub", 2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0, 0, 2'b00, 16'h0, 16'h0);

      launch(2'b10, 16'hFFFF, 16'hABCD);
      monitor("inc", 2'b10, 16'hFFFF, 16'hABCD, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 0, 2'b00, 16'h0, 16'h0);

      launch(2'b11, 16'h8000, 16'h1357);
      monitor("dec", 2'b11, 16'h8000, 16'h1357, 16'h7FFF, 1'b1, 1'b0, 1'b1, 0, 0, 2'b00, 16'h0, 16'h0);

      launch(2'b00, 16'h7FFF, 16'h0001);
      monitor("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 0, 0, 2'b00, 16'h0, 16'h0);

      launch(2'b00, 16'h1111, 16'h2222);
      monitor("add_inject", 2'b00, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1, 0, 2'b00, 16'h0, 16'h0);

      // start raised before the done edge is ignored there and taken on the following edge
      launch(2'b00, 16'hA5A5, 16'h5A5A);
      monitor("add_chain", 2'b00, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 1, 2'b01, 16'h1000, 16'h0001);
      monitor("sub_chained", 2'b01, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00, 16'h0, 16'h0);

      // abort a subtract mid-run
      launch(2'b01, 16'h0123, 16'h0045);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_pre_result", 32'(bus.result), 32'h00DE);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      check("abort_dp", 32'({dp_a, dp_b, dp_s1, dp_s0, dp_cin}), 32'd0);
      check("abort_cout", 32'(bus.cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);

      launch(2'b00, 16'h1234, 16'h0FCD);
      monitor("add_after_rst", 2'b00, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 0, 0, 2'b00, 16'h0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-nibble sequencer for the 4-bit arithmetic unit: the mux-selected B / ~B / 0 / 1 operand feeding a ripple-carry adder with carry-in. The block accepts a wide operation (add, subtract, increment, decrement) and time-multiplexes it onto the unit one nibble at a time, LSB first. It chains each nibble's carry-out into the next nibble's carry-in and assembles the wide result. It sits between the instruction/control logic and the arithmetic unit, and owns the unit's S1, S0, Cin and operand inputs exclusively.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand; word width W = 4*NIBBLES, minimum 1.
- SETTLE, 2, clock cycles each nibble is held on the datapath before capture; minimum 1. The clock period times SETTLE must exceed the unit's worst-case propagation delay.
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 = A+B, 01 = A−B, 10 = A+1, 11 = A−1.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start; ignored for ops 10 and 11.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result is valid.
- result  output  W  assembled result; held until the next accepted start.
- cout  output  1  carry-out of the MSB nibble (for subtract, 1 = no borrow).
- dp_a  output  4  current A nibble to the unit.
- dp_b  output  4  current B nibble to the unit.
- dp_s1, dp_s0  output  1 each  unit operand select: 00 = B, 01 = ~B, 10 = 0, 11 = 1111.
- dp_cin  output  1  unit carry-in.
- dp_d  input  4  unit sum.
- dp_cout  input  1  unit carry-out.
- zero, ovf  output  1 each  flags; present only with ALU_SEQ_FLAGS_EN.

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN when start = 1 at a rising edge. The same edge latches a, b and op, clears the nibble index and the settle counter, and clears result.
- Op mapping to select and first-nibble carry-in:
  - add: S = 00, Cin = 0.
  - sub: S = 01, Cin = 1.
  - inc: S = 10, Cin = 1.
  - dec: S = 11, Cin = 0.
- Nibbles 1..NIBBLES−1 use Cin = the carry captured from the previous nibble.
- dp_a and dp_b are the latched operand nibble selected by the index. All dp_* outputs are stable for the whole nibble window.
- In RUN, the settle counter increments each cycle. When it reaches SETTLE−1, the next edge:
  - writes dp_d into result nibble [index];
  - stores dp_cout as the chain carry;
  - increments the index and clears the counter.
- The capture of the last nibble moves the FSM to IDLE, registers cout = dp_cout, and pulses done.
- start while busy is ignored; it is not queued.
- In IDLE, dp_a = dp_b = 0, S = 00, dp_cin = 0.
- Arithmetic is modulo 2^W. There is no saturation.
- Reset (asynchronous, any time, including mid-operation) forces:
  - FSM = IDLE;
  - busy = done = cout = 0 and result = 0;
  - all dp_* outputs = 0;
  - zero = ovf = 0.
- An aborted operation never produces done.

## Timing
- Start accepted at edge t0: busy = 1 from t0 through the final capture.
- Nibble k is driven from edge t0 + k·SETTLE and captured at edge t0 + (k+1)·SETTLE.
- Final capture at edge t0 + NIBBLES·SETTLE: at that edge done = 1, busy = 0, and result, cout and the flags are updated.
- Latency is NIBBLES·SETTLE cycles; with the defaults, done rises 8 cycles after t0.
- done lasts exactly one cycle. start is next accepted at edge t0 + NIBBLES·SETTLE + 1.
- Outputs are registered, except dp_a and dp_b, which are a mux of registers.

## Configuration
- ALU_SEQ_FLAGS_EN defined: zero and ovf ports exist, updated at the final capture and held until the next accepted start.
  - zero = (result == 0).
  - ovf = signed overflow, defined as (a_msb == y_msb) && (result_msb != a_msb). The effective operand MSB y_msb is b_msb for add, ~b_msb for sub, 0 for inc, 1 for dec.
- ALU_SEQ_FLAGS_EN undefined: the ports and all their logic are absent. Everything else is identical.

## Test plan
The bench drives the real arithmetic unit from dp_*, with NIBBLES = 4 and SETTLE = 2.
- add a = 0x1234, b = 0x0FCD -> result = 0x2201, cout = 0, zero = 0, ovf = 0; done exactly 8 cycles after start; busy high for those 8 cycles.
- sub a = 0x0005, b = 0x0007 -> result = 0xFFFE, cout = 0, ovf = 0. Check dp_s1/dp_s0 = 01 throughout and dp_cin = 1 on nibble 0 only, then the chained carry.
- inc a = 0xFFFF -> result = 0x0000, cout = 1, zero = 1; dp_s1/dp_s0 = 10. Then dec a = 0x8000 -> result = 0x7FFF, cout = 1, ovf = 1.
- add a = 0x7FFF, b = 0x0001 -> result = 0x8000, cout = 0, ovf = 1.
- Pulse start with new operands at cycles 2 and 5 of a running add -> both ignored, the original result is returned. Raise start in the done cycle -> ignored; it is accepted one cycle later.
- Assert rst_n = 0 at cycle 5 of a sub -> immediately busy = 0, result = 0, dp_* = 0. No done follows; the next start behaves normally.
